// File: rtl/modulus_counter_down_if.sv
// modulus_counter_down_if: control/status bundle for the modulus-N down counter
interface modulus_counter_down_if #(parameter int BITS = 9);
  logic enable, load, start, auto_reload, tc, busy;
  logic [BITS-1:0] load_val, q;
  modport master(output enable, load, load_val, start, auto_reload, input q, tc, busy);
  modport slave(input enable, load, load_val, start, auto_reload, output q, tc, busy);
endinterface

// File: rtl/modulus_counter_down.sv
// modulus_counter_down: modulus-N down counter/timer with auto-reload or one-shot stop
// Define MODCNT_PRESCALE_EN to step only on every PRESCALE-th enabled cycle in RUN.
module modulus_counter_down #(
  parameter int MODULUS = 500,
  parameter int PRESCALE = 4,
  parameter int BITS = $clog2(MODULUS)
) (
  input logic clk,
  input logic reset,
  modulus_counter_down_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [BITS-1:0] TOP = BITS'(MODULUS - 1);
  localparam logic [BITS:0] MOD_W = (BITS + 1)'(MODULUS);
  state_t state, state_n;
  logic [BITS-1:0] q_n, clamped;
  logic tc_n, tick, start_go;
  assign bus.busy = state == RUN;
  always_comb begin
    clamped = ({1'b0, bus.load_val} >= MOD_W) ? TOP : bus.load_val;
    start_go = bus.start && state != RUN;
    state_n = state;
    q_n = bus.q;
    tc_n = 1'b0;
    if (bus.load) begin
      q_n = clamped;
      state_n = bus.start ? RUN : (state == DONE ? IDLE : state);
    end else if (start_go) begin
      q_n = state == DONE ? TOP : bus.q;
      state_n = RUN;
    end else if (state == RUN && tick) begin
      q_n = bus.q != '0 ? bus.q - 1'b1 : (bus.auto_reload ? TOP : '0);
      state_n = (bus.q == '0 && !bus.auto_reload) ? DONE : RUN;
      tc_n = bus.q == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.q <= TOP;
      bus.tc <= 1'b0;
    end else begin
      state <= state_n;
      bus.q <= q_n;
      bus.tc <= tc_n;
    end
  end
`ifdef MODCNT_PRESCALE_EN
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre;
  assign tick = bus.enable && pre == PW'(PRESCALE - 1);
  // spacing restarts whenever the count is re-seeded or RUN is left
  always_ff @(posedge clk) begin
    if (reset || bus.load || start_go || state_n != RUN) pre <= '0;
    else if (bus.enable) pre <= tick ? '0 : pre + 1'b1;
  end
`else
  assign tick = bus.enable;
`endif
endmodule

// File: tb/tb_modulus_counter_down.sv
// tb_modulus_counter_down: directed literal checks plus randomized run against a behavioural model
module tb_modulus_counter_down;
  localparam int M = 5;
  localparam int BITS = $clog2(M);
`ifdef MODCNT_PRESCALE_EN
  localparam int PS = 3;
`else
  localparam int PS = 1;
`endif
  logic clk = 1'b0, reset = 1'b1, armed = 1'b0;
  int total = 0, bad = 0;
  int m_q, m_pc;
  bit m_tc, m_run, m_done;
  modulus_counter_down_if #(.BITS(BITS)) bus();
  modulus_counter_down #(.MODULUS(M), .PRESCALE(PS)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // reference: spec rules applied once per clock edge
  always @(posedge clk) begin
    if (reset) begin
      m_q = M - 1; m_tc = 0; m_run = 0; m_done = 0; m_pc = 0;
    end else begin
      m_tc = 0;
      if (bus.load) begin
        m_q = bus.load_val >= M ? M - 1 : int'(bus.load_val);
        m_pc = 0;
        if (bus.start) begin m_run = 1; m_done = 0; end
        else m_done = 0;
      end else if (bus.start && !m_run) begin
        if (m_done) m_q = M - 1;
        m_run = 1; m_done = 0; m_pc = 0;
      end else if (m_run && bus.enable) begin
        m_pc++;
        if (m_pc == PS) begin
          m_pc = 0;
          if (m_q > 0) m_q--;
          else begin
            m_tc = 1;
            if (bus.auto_reload) m_q = M - 1;
            else begin m_run = 0; m_done = 1; end
          end
        end
      end
      if (!m_run) m_pc = 0;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("model_q", int'(bus.q), m_q);
      chk("model_tc", int'(bus.tc), int'(m_tc));
      chk("model_busy", int'(bus.busy), int'(m_run));
    end
  end
  task automatic cyc(input bit en, input bit ld, input int lv, input bit st, input bit ar, input bit rs);
    bus.enable = en; bus.load = ld; bus.load_val = BITS'(lv); bus.start = st; bus.auto_reload = ar; reset = rs;
    @(negedge clk);
  endtask
  initial begin
    int exp_q[5] = '{3, 2, 1, 0, 4};
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    armed = 1'b1;
    chk("rst_q", int'(bus.q), 4);
    chk("rst_tc", int'(bus.tc), 0);
    chk("rst_busy", int'(bus.busy), 0);
`ifndef MODCNT_PRESCALE_EN
    cyc(1, 0, 0, 1, 1, 0);
    chk("start_q", int'(bus.q), 4);
    chk("start_busy", int'(bus.busy), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 1, 0);
      chk("wrap_q", int'(bus.q), exp_q[i]);
      chk("wrap_tc", int'(bus.tc), i == 4 ? 1 : 0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    chk("tc_fall", int'(bus.tc), 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("os_zero", int'(bus.q), 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("os_q", int'(bus.q), 0);
    chk("os_tc", int'(bus.tc), 1);
    chk("os_busy", int'(bus.busy), 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("done_tc", int'(bus.tc), 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk("restart_q", int'(bus.q), 4);
    chk("restart_busy", int'(bus.busy), 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 7, 0, 0, 0);
    chk("clamp_q", int'(bus.q), 4);
    chk("clamp_tc", int'(bus.tc), 0);
    chk("clamp_busy", int'(bus.busy), 1);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("hold_q", int'(bus.q), 3);
    cyc(1, 0, 0, 0, 1, 0);
    chk("resume_q", int'(bus.q), 2);
    cyc(1, 0, 0, 0, 1, 1);
    chk("midrst_q", int'(bus.q), 4);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_tc", int'(bus.tc), 0);
`endif
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7),
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
